// File: rtl/tcp_rx_hdr_strip.sv
// rtl/tcp_rx_hdr_strip.sv - TCP receive header parser and payload realigner
// Optional statistics counters: define TCP_RX_HDR_STRIP_STATS_EN
module tcp_rx_hdr_strip (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tcp_format_val,
  output logic         tcp_format_rdy,
  input  logic [31:0]  tcp_format_src_ip,
  input  logic [31:0]  tcp_format_dst_ip,
  input  logic [15:0]  tcp_format_tcp_len,
  input  logic [511:0] tcp_format_data,
  input  logic         tcp_format_last,
  input  logic [5:0]   tcp_format_padbytes,
  output logic         hdr_val,
  input  logic         hdr_rdy,
  output logic [31:0]  hdr_src_ip,
  output logic [31:0]  hdr_dst_ip,
  output logic [15:0]  hdr_src_port,
  output logic [15:0]  hdr_dst_port,
  output logic [31:0]  hdr_seq_num,
  output logic [31:0]  hdr_ack_num,
  output logic [7:0]   hdr_flags,
  output logic [15:0]  hdr_win,
  output logic [15:0]  hdr_payload_len,
  output logic         payload_val,
  input  logic         payload_rdy,
  output logic [511:0] payload_data,
  output logic         payload_last,
  output logic [5:0]   payload_padbytes,
  output logic [31:0]  stat_pkt_cnt,
  output logic [15:0]  stat_drop_cnt
);

  typedef enum logic [2:0] {
    S_HDR,
    S_PAYLOAD,
    S_DRAIN,
    S_DROP,
    S_WAIT_HDR
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [511:0] r_carry;
  logic [15:0]  r_rem;
  logic [5:0]   r_hdr_bytes;
  logic         r_in_done;
  logic         r_hdr_val;
  logic [31:0]  r_src_ip;
  logic [31:0]  r_dst_ip;
  logic [15:0]  r_src_port;
  logic [15:0]  r_dst_port;
  logic [31:0]  r_seq;
  logic [31:0]  r_ack;
  logic [7:0]   r_flags;
  logic [15:0]  r_win;
  logic [15:0]  r_plen;

  logic [3:0]    w_doff;
  logic [5:0]    w_hbytes;
  logic          w_bad;
  logic [15:0]   w_plen;
  logic [15:0]   w_room_in;
  logic [15:0]   w_room;
  logic          w_hdr_accept;
  logic          w_hdr_fire;
  logic          w_hdr_pend;
  logic          w_pay_fire;
  logic          w_beat_last;
  logic [15:0]   w_rem_sub;
  logic          w_rdy;
  logic          w_pay_val;
  logic          w_use_in;
  logic [1023:0] w_cat;
  logic [1023:0] w_shift;
  logic          w_unused;

  // Header is at most 60 bytes, so it always sits entirely inside the first flit
  assign w_doff    = tcp_format_data[415:412];
  assign w_hbytes  = {w_doff, 2'b00};
  assign w_bad     = (w_doff < 4'd5) || ({10'd0, w_hbytes} > tcp_format_tcp_len);
  assign w_plen    = tcp_format_tcp_len - {10'd0, w_hbytes};
  assign w_room_in = 16'd64 - {10'd0, w_hbytes};
  assign w_room    = 16'd64 - {10'd0, r_hdr_bytes};

  assign w_hdr_accept = (r_state == S_HDR) && tcp_format_val;
  assign w_hdr_fire   = r_hdr_val && hdr_rdy;
  assign w_hdr_pend   = r_hdr_val && !hdr_rdy;
  assign w_pay_fire   = w_pay_val && payload_rdy;
  assign w_beat_last  = (r_rem <= 16'd64);
  assign w_rem_sub    = r_rem - 16'd64;

  always_comb begin
    w_state_nxt = r_state;
    w_rdy       = 1'b0;
    w_pay_val   = 1'b0;
    w_use_in    = 1'b0;
    case (r_state)
      S_HDR: begin
        w_rdy = 1'b1;
        if (tcp_format_val) begin
          if (w_bad)
            w_state_nxt = tcp_format_last ? S_HDR : S_DROP;
          else if (w_plen == 16'd0)
            w_state_nxt = tcp_format_last ? S_WAIT_HDR : S_DROP;
          else if (tcp_format_last || (w_plen <= w_room_in))
            w_state_nxt = S_DRAIN;
          else
            w_state_nxt = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        w_rdy     = payload_rdy;
        w_pay_val = tcp_format_val;
        w_use_in  = 1'b1;
        if (tcp_format_val && payload_rdy) begin
          if (w_beat_last)
            w_state_nxt = tcp_format_last ? (w_hdr_pend ? S_WAIT_HDR : S_HDR) : S_DROP;
          else if (tcp_format_last || (w_rem_sub <= w_room))
            w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_pay_val = 1'b1;
        if (payload_rdy && w_beat_last)
          w_state_nxt = r_in_done ? (w_hdr_pend ? S_WAIT_HDR : S_HDR) : S_DROP;
      end
      S_DROP: begin
        w_rdy = 1'b1;
        if (tcp_format_val && tcp_format_last)
          w_state_nxt = w_hdr_pend ? S_WAIT_HDR : S_HDR;
      end
      S_WAIT_HDR: begin
        if (!w_hdr_pend)
          w_state_nxt = S_HDR;
      end
      default: w_state_nxt = S_HDR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_HDR;
      r_carry     <= '0;
      r_rem       <= '0;
      r_hdr_bytes <= '0;
      r_in_done   <= 1'b0;
      r_hdr_val   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_hdr_fire)
        r_hdr_val <= 1'b0;
      case (r_state)
        S_HDR: begin
          if (tcp_format_val && !w_bad) begin
            r_hdr_val   <= 1'b1;
            r_carry     <= tcp_format_data;
            r_rem       <= w_plen;
            r_hdr_bytes <= w_hbytes;
            r_in_done   <= tcp_format_last;
          end
        end
        S_PAYLOAD: begin
          if (w_pay_fire) begin
            r_carry   <= tcp_format_data;
            r_rem     <= w_beat_last ? 16'd0 : w_rem_sub;
            r_in_done <= tcp_format_last;
          end
        end
        S_DRAIN: begin
          // Only a truncated segment reaches a second drain beat; it is zero-filled
          if (w_pay_fire) begin
            r_carry <= '0;
            r_rem   <= w_beat_last ? 16'd0 : w_rem_sub;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src_ip   <= '0;
      r_dst_ip   <= '0;
      r_src_port <= '0;
      r_dst_port <= '0;
      r_seq      <= '0;
      r_ack      <= '0;
      r_flags    <= '0;
      r_win      <= '0;
      r_plen     <= '0;
    end else if (w_hdr_accept && !w_bad) begin
      r_src_ip   <= tcp_format_src_ip;
      r_dst_ip   <= tcp_format_dst_ip;
      r_src_port <= tcp_format_data[511:496];
      r_dst_port <= tcp_format_data[495:480];
      r_seq      <= tcp_format_data[479:448];
      r_ack      <= tcp_format_data[447:416];
      r_flags    <= tcp_format_data[407:400];
      r_win      <= tcp_format_data[399:384];
      r_plen     <= w_plen;
    end
  end

  // Output beat n = carry bytes [H..63] followed by current flit bytes [0..H-1]
  assign w_cat   = {r_carry, (w_use_in ? tcp_format_data : 512'd0)};
  assign w_shift = w_cat << {r_hdr_bytes, 3'b000};

  assign tcp_format_rdy   = w_rdy & rst_n;
  assign payload_val      = w_pay_val;
  assign payload_data     = w_shift[1023:512];
  assign payload_last     = w_pay_val && w_beat_last;
  assign payload_padbytes = (w_pay_val && w_beat_last) ? (6'd0 - r_rem[5:0]) : 6'd0;

  assign hdr_val         = r_hdr_val;
  assign hdr_src_ip      = r_src_ip;
  assign hdr_dst_ip      = r_dst_ip;
  assign hdr_src_port    = r_src_port;
  assign hdr_dst_port    = r_dst_port;
  assign hdr_seq_num     = r_seq;
  assign hdr_ack_num     = r_ack;
  assign hdr_flags       = r_flags;
  assign hdr_win         = r_win;
  assign hdr_payload_len = r_plen;

  assign w_unused = ^{tcp_format_padbytes, w_shift[511:0]};

`ifdef TCP_RX_HDR_STRIP_STATS_EN
  logic [31:0] r_pkt_cnt;
  logic [15:0] r_drop_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pkt_cnt  <= '0;
      r_drop_cnt <= '0;
    end else if (w_hdr_accept) begin
      if (!w_bad)
        r_pkt_cnt <= r_pkt_cnt + 32'd1;
      else if (r_drop_cnt != 16'hFFFF)
        r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign stat_pkt_cnt  = r_pkt_cnt;
  assign stat_drop_cnt = r_drop_cnt;
`else
  assign stat_pkt_cnt  = 32'd0;
  assign stat_drop_cnt = 16'd0;
`endif

endmodule
